// File: rtl/des_out_serializer.sv
// DES output serializer: buffers 64-bit result words in a small FIFO and streams them MSB-first
// as OUT_WIDTH chunks over valid/ready. Optional even-parity output guarded by SER_PARITY_EN.
module des_out_serializer #(
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [OUT_WIDTH-1:0]  o_chunk,
  output logic                  o_chunk_valid,
  input  logic                  i_chunk_ready,
  output logic                  o_last,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
`ifdef SER_PARITY_EN
  output logic                  o_parity,
`endif
  input  logic                  i_clr_ovf
);

  localparam int NCHUNK = DATA_WIDTH / OUT_WIDTH;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NCHUNK - 1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [OUT_WIDTH-1:0] top_chunk(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1 -: OUT_WIDTH];
  endfunction

`ifdef SER_PARITY_EN
  function automatic logic even_parity(input logic [OUT_WIDTH-1:0] c);
    return ^c;
  endfunction
`endif

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  vld_q;
  logic                  last_q;
  logic                  ovf_q;
`ifdef SER_PARITY_EN
  logic                  parity_q;
`endif

  logic                  xfer, pop, push, fifo_has_data;
  logic [DATA_WIDTH-1:0] head, shifted;
  logic [IDX_W-1:0]      idx_nxt;

  // Handshake / FIFO control decode
  always_comb begin
    fifo_has_data = (count != '0);
    xfer          = vld_q && i_chunk_ready;
    // A pop refills the shift register: from idle, or on the last-chunk handshake
    pop           = fifo_has_data && ((state == IDLE) || (xfer && last_q));
    // Full FIFO still takes a word when the head leaves on the same edge
    push          = i_valid && ((count != DEPTH_CNT) || pop);
    head          = mem[rd_ptr];
    shifted       = shift_q << OUT_WIDTH;
    idx_nxt       = idx_q + IDX_W'(1);
    unique case ({push, pop})
      2'b10:   count_nxt = count + (DEPTH_LOG2+1)'(1);
      2'b01:   count_nxt = count - (DEPTH_LOG2+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count <= count_nxt;
      if (i_valid && !push)
        ovf_q <= 1'b1;
      else if (i_clr_ovf)
        ovf_q <= 1'b0;
    end
  end

  // Serializer FSM: shift register, chunk index and registered chunk outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            state    <= SEND;
            shift_q  <= head;
            idx_q    <= '0;
            vld_q    <= 1'b1;
            last_q   <= (LAST_IDX == '0);
`ifdef SER_PARITY_EN
            parity_q <= even_parity(top_chunk(head));
`endif
          end
        end
        SEND: begin
          if (xfer) begin
            if (!last_q) begin
              shift_q  <= shifted;
              idx_q    <= idx_nxt;
              last_q   <= (idx_nxt == LAST_IDX);
`ifdef SER_PARITY_EN
              parity_q <= even_parity(top_chunk(shifted));
`endif
            end else if (pop) begin
              // Next word follows immediately with no bubble
              shift_q  <= head;
              idx_q    <= '0;
              last_q   <= (LAST_IDX == '0);
`ifdef SER_PARITY_EN
              parity_q <= even_parity(top_chunk(head));
`endif
            end else begin
              state    <= IDLE;
              vld_q    <= 1'b0;
              last_q   <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          vld_q  <= 1'b0;
          last_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_chunk       = top_chunk(shift_q);
  assign o_chunk_valid = vld_q;
  assign o_last        = last_q;
  assign o_full        = (count == DEPTH_CNT);
  assign o_empty       = (count == '0) && (state == IDLE);
  assign o_overflow    = ovf_q;
`ifdef SER_PARITY_EN
  assign o_parity      = parity_q;
`endif

endmodule

// File: tb/tb_des_out_serializer.sv
// Self-checking bench for des_out_serializer: directed test-plan scenarios plus randomized
// traffic checked against a queue-based reference model of the FIFO and chunk stream.
module tb_des_out_serializer;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] i_data;
  logic        i_valid;
  logic [7:0]  o_chunk;
  logic        o_chunk_valid;
  logic        i_chunk_ready;
  logic        o_last, o_full, o_empty, o_overflow;
  logic        i_clr_ovf;
`ifdef SER_PARITY_EN
  logic        o_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_busy;
  logic [63:0] m_cur;
  int          m_idx;
  logic [63:0] m_q[$];
  logic [63:0] m_acc[$];
  bit          m_ovf;
  logic [7:0]  rx_q[$];

  des_out_serializer #(.DATA_WIDTH(64), .OUT_WIDTH(8), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_chunk(o_chunk), .o_chunk_valid(o_chunk_valid), .i_chunk_ready(i_chunk_ready),
    .o_last(o_last), .o_full(o_full), .o_empty(o_empty), .o_overflow(o_overflow),
`ifdef SER_PARITY_EN
    .o_parity(o_parity),
`endif
    .i_clr_ovf(i_clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_cur = '0; m_idx = 0; m_ovf = 0;
    m_q.delete();
  endtask

  // One clock edge of the specified behaviour, evaluated on the pre-edge inputs
  task automatic model_step();
    bit xfer, lastc, popping, accept;
    xfer    = m_busy && i_chunk_ready;
    lastc   = (m_idx == N-1);
    popping = (m_q.size() > 0) && (!m_busy || (xfer && lastc));
    accept  = i_valid && ((m_q.size() < DEPTH) || popping);
    if (xfer && !lastc) m_idx++;
    else if (popping) begin m_cur = m_q.pop_front(); m_idx = 0; m_busy = 1; end
    else if (xfer) m_busy = 0;
    if (accept) begin m_q.push_back(i_data); m_acc.push_back(i_data); end
    if (i_valid && !accept) m_ovf = 1;
    else if (i_clr_ovf) m_ovf = 0;
  endtask

  task automatic cycle();
    if (rst_n && o_chunk_valid && i_chunk_ready) rx_q.push_back(o_chunk);
    if (!rst_n) model_reset(); else model_step();
    @(posedge clk); #1;
  endtask

  function automatic logic [13:0] obs_vec();
    logic p;
`ifdef SER_PARITY_EN
    p = o_chunk_valid ? o_parity : 1'b0;
`else
    p = 1'b0;
`endif
    return {o_chunk_valid, o_last, o_full, o_empty, o_overflow,
            (o_chunk_valid ? o_chunk : 8'h00), p};
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [7:0] ch;
    logic p;
    ch = m_busy ? m_cur[63-8*m_idx -: 8] : 8'h00;
`ifdef SER_PARITY_EN
    p = ^ch;
`else
    p = 1'b0;
`endif
    return {m_busy, (m_busy && m_idx == N-1), (m_q.size() == DEPTH),
            (m_q.size() == 0 && !m_busy), m_ovf, ch, p};
  endfunction

  task automatic test_reset();
    rst_n = 0; i_data = '0; i_valid = 0; i_chunk_ready = 0; i_clr_ovf = 0;
    model_reset();
    #1;
    repeat (3) cycle();
    n_checks++;
    if ({o_chunk, o_chunk_valid, o_last, o_full, o_empty, o_overflow} !== {8'h00, 5'b00010}) begin
      n_fail++;
      $display("FAIL reset_hold: got chunk=%h v=%b l=%b f=%b e=%b o=%b want 00 0 0 0 1 0",
               o_chunk, o_chunk_valid, o_last, o_full, o_empty, o_overflow);
    end
    rst_n = 1;
    cycle();
    n_checks++;
    if (obs_vec() !== exp_vec() || o_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single_word();
    logic [63:0] w = 64'h0123456789ABCDEF;
    rx_q.delete();
    i_chunk_ready = 1; i_data = w; i_valid = 1;
    cycle();
    i_valid = 0;
    n_checks++;
    if (o_chunk_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_latency: valid=%b want 0 one edge after strobe", o_chunk_valid);
    end
    cycle();
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if ({o_chunk_valid, o_last, o_chunk} !== {1'b1, (k == N-1), w[63-8*k -: 8]}) begin
        n_fail++;
        $display("FAIL single_chunk%0d: got v=%b l=%b c=%h want v=1 l=%b c=%h",
                 k, o_chunk_valid, o_last, o_chunk, (k == N-1), w[63-8*k -: 8]);
      end
      cycle();
    end
    n_checks++;
    if ({o_empty, o_chunk_valid} !== 2'b10 || rx_q.size() != N) begin
      n_fail++;
      $display("FAIL single_done: empty=%b valid=%b rx=%0d want 1 0 8", o_empty, o_chunk_valid, rx_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] w = 64'h0123456789ABCDEF;
    logic [7:0]  prev_c;
    logic        prev_l, prev_stall;
    rx_q.delete();
    i_chunk_ready = 1; i_data = w; i_valid = 1;
    cycle();
    i_valid = 0;
    prev_stall = 0; prev_c = '0; prev_l = 0;
    for (int c = 0; c < 40; c++) begin
      i_chunk_ready = (c % 3 == 0);
      if (prev_stall) begin
        n_checks++;
        if ({o_chunk, o_last} !== {prev_c, prev_l}) begin
          n_fail++;
          $display("FAIL bp_stall_hold: got c=%h l=%b want c=%h l=%b", o_chunk, o_last, prev_c, prev_l);
        end
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL bp_model: got %h want %h", obs_vec(), exp_vec());
      end
      prev_stall = o_chunk_valid && !i_chunk_ready;
      prev_c = o_chunk; prev_l = o_last;
      cycle();
    end
    n_checks++;
    if (rx_q.size() != N) begin
      n_fail++; $display("FAIL bp_count: got %0d chunks want %0d", rx_q.size(), N);
    end else begin
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (rx_q[k] !== w[63-8*k -: 8]) begin
          n_fail++; $display("FAIL bp_seq%0d: got %h want %h", k, rx_q[k], w[63-8*k -: 8]);
        end
      end
    end
    i_chunk_ready = 1;
  endtask

  task automatic test_overflow();
    logic [63:0] base = 64'h1111222233334400;
    logic [63:0] got;
    rx_q.delete();
    i_chunk_ready = 0;
    for (int k = 1; k <= 6; k++) begin
      i_data = base + 64'(k); i_valid = 1;
      cycle();
      if (k == 5) begin
        n_checks++;
        if ({o_full, o_overflow} !== 2'b10) begin
          n_fail++; $display("FAIL ovf_full5: full=%b ovf=%b want 1 0", o_full, o_overflow);
        end
      end
    end
    i_valid = 0;
    n_checks++;
    if ({o_full, o_overflow} !== 2'b11) begin
      n_fail++; $display("FAIL ovf_drop6: full=%b ovf=%b want 1 1", o_full, o_overflow);
    end
    cycle();
    n_checks++;
    if (o_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: ovf=%b want 1", o_overflow);
    end
    i_clr_ovf = 1; cycle(); i_clr_ovf = 0;
    n_checks++;
    if (o_overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: ovf=%b want 0", o_overflow);
    end
    i_chunk_ready = 1;
    for (int c = 0; c < 100 && !o_empty; c++) cycle();
    n_checks++;
    if (o_empty !== 1'b1 || rx_q.size() != 5*N) begin
      n_fail++; $display("FAIL ovf_drain: empty=%b chunks=%0d want 1 %0d", o_empty, rx_q.size(), 5*N);
    end else begin
      for (int k = 0; k < 5; k++) begin
        got = '0;
        for (int j = 0; j < N; j++) got = {got[55:0], rx_q[k*N+j]};
        n_checks++;
        if (got !== base + 64'(k+1)) begin
          n_fail++; $display("FAIL ovf_word%0d: got %h want %h", k+1, got, base + 64'(k+1));
        end
      end
    end
  endtask

  task automatic test_full_same_edge();
    logic [63:0] base = 64'hCAFE000000000000;
    logic [63:0] got;
    bit seen;
    rx_q.delete();
    i_chunk_ready = 0;
    for (int k = 1; k <= 5; k++) begin
      i_data = base + 64'(k); i_valid = 1; cycle();
    end
    i_valid = 0;
    n_checks++;
    if (o_full !== 1'b1) begin
      n_fail++; $display("FAIL same_prefull: full=%b want 1", o_full);
    end
    i_chunk_ready = 1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (o_last) seen = 1; else cycle();
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL same_last_timeout: o_last=%b want 1 within 20 cycles", o_last);
    end
    i_data = base + 64'd6; i_valid = 1; cycle(); i_valid = 0;
    n_checks++;
    if ({o_overflow, o_full} !== 2'b01) begin
      n_fail++; $display("FAIL same_edge_push: ovf=%b full=%b want 0 1", o_overflow, o_full);
    end
    for (int c = 0; c < 100 && !o_empty; c++) cycle();
    n_checks++;
    if (rx_q.size() != 6*N) begin
      n_fail++; $display("FAIL same_drain: chunks=%0d want %0d", rx_q.size(), 6*N);
    end else begin
      for (int k = 0; k < 6; k++) begin
        got = '0;
        for (int j = 0; j < N; j++) got = {got[55:0], rx_q[k*N+j]};
        n_checks++;
        if (got !== base + 64'(k+1)) begin
          n_fail++; $display("FAIL same_word%0d: got %h want %h", k+1, got, base + 64'(k+1));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    rx_q.delete();
    i_chunk_ready = 1;
    i_data = 64'hA1A2A3A4A5A6A7A8; i_valid = 1; cycle();
    i_data = 64'hB1B2B3B4B5B6B7B8; cycle();
    i_valid = 0;
    for (int c = 0; c < 2*N; c++) begin
      n_checks++;
      if (o_chunk_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL b2b_cycle%0d: valid=%b got %h want %h", c, o_chunk_valid, obs_vec(), exp_vec());
      end
      cycle();
    end
    n_checks++;
    if (o_empty !== 1'b1 || rx_q.size() != 2*N) begin
      n_fail++; $display("FAIL b2b_done: empty=%b chunks=%0d want 1 %0d", o_empty, rx_q.size(), 2*N);
    end
  endtask

  task automatic test_reset_mid_word();
    rx_q.delete();
    i_chunk_ready = 1;
    i_data = 64'h0123456789ABCDEF; i_valid = 1; cycle(); i_valid = 0;
    i_data = 64'hFEDCBA9876543210; i_valid = 1; cycle(); i_valid = 0;
    for (int c = 0; c < 20 && rx_q.size() < 3; c++) cycle();
    rst_n = 0;
    #1;
    n_checks++;
    if ({o_chunk, o_chunk_valid, o_last, o_full, o_empty, o_overflow} !== {8'h00, 5'b00010}) begin
      n_fail++;
      $display("FAIL rst_mid_async: got chunk=%h v=%b l=%b f=%b e=%b o=%b want 00 0 0 0 1 0",
               o_chunk, o_chunk_valid, o_last, o_full, o_empty, o_overflow);
    end
`ifdef SER_PARITY_EN
    n_checks++;
    if (o_parity !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_parity: got %b want 0", o_parity);
    end
`endif
    @(posedge clk); #1;
    cycle();
    rst_n = 1;
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (o_chunk_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_residual%0d: valid=%b want 0", c, o_chunk_valid);
      end
      cycle();
    end
    n_checks++;
    if (rx_q.size() != 3 || o_empty !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_total: chunks=%0d empty=%b want 3 1", rx_q.size(), o_empty);
    end
  endtask

  task automatic test_random();
    int idx;
    rx_q.delete();
    m_acc.delete();
    for (int c = 0; c < 600; c++) begin
      i_valid       = ($urandom_range(0, 99) < 30);
      i_data        = {$urandom, $urandom};
      i_chunk_ready = ($urandom_range(0, 99) < 60);
      i_clr_ovf     = ($urandom_range(0, 99) < 5);
      cycle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rand_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    i_valid = 0; i_clr_ovf = 0; i_chunk_ready = 1;
    for (int c = 0; c < 100 && !o_empty; c++) cycle();
    n_checks++;
    if (o_empty !== 1'b1 || rx_q.size() != m_acc.size()*N) begin
      n_fail++;
      $display("FAIL rand_drain: empty=%b chunks=%0d want 1 %0d", o_empty, rx_q.size(), m_acc.size()*N);
    end else begin
      idx = 0;
      for (int k = 0; k < m_acc.size(); k++) begin
        for (int j = 0; j < N; j++) begin
          n_checks++;
          if (rx_q[idx] !== m_acc[k][63-8*j -: 8]) begin
            n_fail++; $display("FAIL rand_stream%0d: got %h want %h", idx, rx_q[idx], m_acc[k][63-8*j -: 8]);
          end
          idx++;
        end
      end
    end
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity();
    i_chunk_ready = 1;
    i_data = 64'h0103000000000000; i_valid = 1; cycle(); i_valid = 0;
    cycle();
    n_checks++;
    if ({o_chunk, o_parity} !== {8'h01, 1'b1}) begin
      n_fail++; $display("FAIL parity_01: chunk=%h parity=%b want 01 1", o_chunk, o_parity);
    end
    cycle();
    n_checks++;
    if ({o_chunk, o_parity} !== {8'h03, 1'b0}) begin
      n_fail++; $display("FAIL parity_03: chunk=%h parity=%b want 03 0", o_chunk, o_parity);
    end
    for (int c = 0; c < 20 && !o_empty; c++) cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_overflow();
    test_full_same_edge();
    test_back_to_back();
`ifdef SER_PARITY_EN
    test_parity();
`endif
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
